// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among N_REQ requesters.
// Requester tags ride a shift pipeline matched to the adder latency.
module fpadd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3,
    localparam int TAG_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                fpu_in_valid,
    output logic [31:0]         fpu_a,
    output logic [31:0]         fpu_b,
    input  logic [31:0]         fpu_result,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_data,
    output logic [15:0]         ops_issued
);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } tag_t;

    tag_t [LATENCY:0] tag_pipe;
    tag_t             tail;

    logic [N_REQ-1:0] outstanding;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic [TAG_W-1:0] last_grant;
    logic [TAG_W-1:0] grant_idx;
    logic             hs;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    assign eligible  = req_valid & ~outstanding;
    assign tail      = tag_pipe[LATENCY];
    assign done      = tail.vld ? (N_REQ'(1) << tail.tag) : '0;
    assign req_ready = grant;

    // Scan starts just past the previous winner so every requester gets a turn.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = last_grant;
        hs        = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(last_grant) + 1 + i) % N_REQ;
            if (!hs && eligible[j]) begin
                hs        = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = TAG_W'(j);
                sel_a     = req_a[32*j +: 32];
                sel_b     = req_b[32*j +: 32];
            end
        end
        if (!rst_n) begin
            grant = '0;
            hs    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_pipe     <= '0;
            outstanding  <= '0;
            fpu_in_valid <= 1'b0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            ops_issued   <= '0;
            last_grant   <= TAG_W'(N_REQ - 1);
        end else begin
            fpu_in_valid <= hs;
            tag_pipe[0]  <= '{vld: hs, tag: grant_idx};
            for (int k = 1; k <= LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            // grant never overlaps done: a requester awaiting its result is ineligible.
            outstanding <= (outstanding & ~done) | grant;
            resp_valid  <= done;
            if (tail.vld) begin
                resp_data <= fpu_result;
            end
            if (hs) begin
                fpu_a      <= sel_a;
                fpu_b      <= sel_b;
                last_grant <= grant_idx;
                ops_issued <= ops_issued + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: behavioural adder pipeline plus an issue-order
// scoreboard of expected responses.
module tb_fpadd_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic              fpu_in_valid;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic [31:0]       fpu_result;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_data;
    logic [15:0]       ops_issued;

    logic [7:0]        w_req_valid = '0;
    logic [255:0]      w_a = '0;
    logic [255:0]      w_b = '0;
    logic [7:0]        w_ready;
    logic              w_fin;
    logic [31:0]       w_fa;
    logic [31:0]       w_fb;
    logic [31:0]       w_res = '0;
    logic [7:0]        w_rv;
    logic [31:0]       w_rd;
    logic [15:0]       w_ops;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;

    typedef struct {
        int          tag;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_d [LAT];
    logic        m_v [LAT] = '{default: 1'b0};

    logic [N-1:0] cont_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};

    fpadd_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .fpu_in_valid(fpu_in_valid), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .ops_issued(ops_issued)
    );

    fpadd_arbiter #(.N_REQ(8), .LATENCY(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_a(w_a), .req_b(w_b),
        .req_ready(w_ready),
        .fpu_in_valid(w_fin), .fpu_a(w_fa), .fpu_b(w_fb),
        .fpu_result(w_res),
        .resp_valid(w_rv), .resp_data(w_rd),
        .ops_issued(w_ops)
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact for the 1.0 + 2.0 case, an integer sum otherwise.
    function automatic logic [31:0] model_add(logic [31:0] a, logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        m_v[0] <= fpu_in_valid;
        m_d[0] <= model_add(fpu_a, fpu_b);
        for (int k = 1; k < LAT; k++) begin
            m_v[k] <= m_v[k-1];
            m_d[k] <= m_d[k-1];
        end
    end
    assign fpu_result = m_v[LAT-1] ? m_d[LAT-1] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    exp_q.push_back('{i, model_add(req_a[i*32 +: 32], req_b[i*32 +: 32]),
                                      cyc + LAT + 2});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        rst_n = 1'b0;
        repeat (2) step();
        total++;
        if (req_ready !== '0)
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        else pass_cnt++;
        total++;
        if ({fpu_in_valid, fpu_a, fpu_b, resp_valid, resp_data, ops_issued} !== '0)
            $display("FAIL reset_outputs: fin=%b a=%h b=%h rv=%b rd=%h ops=%h want all 0",
                     fpu_in_valid, fpu_a, fpu_b, resp_valid, resp_data, ops_issued);
        else pass_cnt++;
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL single_ready: got %b want 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        total++;
        if (fpu_in_valid !== 1'b1 || fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000)
            $display("FAIL single_issue: fin=%b a=%h b=%h want 1 3f800000 40000000",
                     fpu_in_valid, fpu_a, fpu_b);
        else pass_cnt++;
        total++;
        if (ops_issued !== 16'd1)
            $display("FAIL single_ops: got %0d want 1", ops_issued);
        else pass_cnt++;
        repeat (3) step();
        total++;
        if (resp_valid !== '0)
            $display("FAIL single_early: resp_valid=%b want 0000 at T+4", resp_valid);
        else pass_cnt++;
        step();
        total++;
        if (resp_valid !== 4'b0001 || resp_data !== 32'h4040_0000)
            $display("FAIL single_resp: got %b %h want 0001 40400000", resp_valid, resp_data);
        else pass_cnt++;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL single_sb: queue empty, want one entry");
        end else begin
            e = exp_q.pop_front();
            if (cyc != e.due || resp_data !== e.data)
                $display("FAIL single_sb: cyc=%0d data=%h want cyc=%0d data=%h",
                         cyc, resp_data, e.due, e.data);
            else pass_cnt++;
        end
    endtask

    task automatic test_contention();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            req_a[k*32 +: 32] = $urandom;
            req_b[k*32 +: 32] = $urandom;
        end
        req_valid = '1;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (req_ready !== cont_tab[i])
                $display("FAIL cont_ready_%0d: got %b want %b", i, req_ready, cont_tab[i]);
            else pass_cnt++;
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL cont_resp: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL cont_resp: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL cont_drain: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL cont_drain: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        total++;
        if (exp_q.size() != 0)
            $display("FAIL cont_missing: %0d responses outstanding want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_a[k*32 +: 32] = $urandom;
            req_b[k*32 +: 32] = $urandom;
        end
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010)
            $display("FAIL rot_lone: got %b want 0010", req_ready);
        else pass_cnt++;
        step();
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b1000)
            $display("FAIL rot_first: got %b want 1000", req_ready);
        else pass_cnt++;
        step();
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL rot_second: got %b want 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rot_resp: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL rot_resp: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        total++;
        if (exp_q.size() != 0)
            $display("FAIL rot_missing: %0d responses outstanding want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   last_hs;
        int   hs_n;
        last_hs = -1;
        hs_n = 0;
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 26; c++) begin
            req_a[64 +: 32] = $urandom;
            req_b[64 +: 32] = $urandom;
            #1;
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_resp: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL b2b_resp: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
                total++;
                if (req_ready !== 4'b0100)
                    $display("FAIL b2b_regrant: req_ready=%b want 0100 with resp", req_ready);
                else pass_cnt++;
            end
            if (req_ready[2]) begin
                if (last_hs >= 0) begin
                    total++;
                    if (cyc - last_hs != LAT + 2)
                        $display("FAIL b2b_gap: got %0d want %0d", cyc - last_hs, LAT + 2);
                    else pass_cnt++;
                end
                last_hs = cyc;
                hs_n++;
            end
            step();
        end
        req_valid = '0;
        total++;
        if (hs_n != 6)
            $display("FAIL b2b_count: got %0d want 6", hs_n);
        else pass_cnt++;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_drain: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL b2b_drain: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        total++;
        if (exp_q.size() != 0)
            $display("FAIL b2b_missing: %0d responses outstanding want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_a[k*32 +: 32] = $urandom | 32'h1;
            req_b[k*32 +: 32] = $urandom;
        end
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mid_pre: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL mid_pre: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== '0)
            $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        req_valid = '0;
        total++;
        if ({fpu_in_valid, fpu_a, fpu_b, resp_valid, resp_data, ops_issued} !== '0)
            $display("FAIL mid_outputs: fin=%b a=%h b=%h rv=%b rd=%h ops=%h want all 0",
                     fpu_in_valid, fpu_a, fpu_b, resp_valid, resp_data, ops_issued);
        else pass_cnt++;
        for (int c = 0; c < 8; c++) begin
            step();
            total++;
            if (resp_valid !== '0)
                $display("FAIL mid_ghost_%0d: resp_valid=%b want 0000", c, resp_valid);
            else pass_cnt++;
        end
        req_valid = 4'b0111;
        #1;
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL mid_first_grant: got %b want 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mid_post: got %b with nothing in flight", resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_valid !== N'(1 << e.tag) || resp_data !== e.data || cyc != e.due)
                        $display("FAIL mid_post: got %b %h cyc %0d want %b %h cyc %0d",
                                 resp_valid, resp_data, cyc, N'(1 << e.tag), e.data, e.due);
                    else pass_cnt++;
                end
            end
            step();
        end
        total++;
        if (exp_q.size() != 0)
            $display("FAIL mid_missing: %0d responses outstanding want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        int   cnt;
        logic hs;
        cnt = 0;
        do_reset();
        w_req_valid = '1;
        for (int c = 0; c < 70000 && cnt < 65537; c++) begin
            #1;
            hs = |(w_req_valid & w_ready);
            step();
            if (hs) begin
                cnt++;
                if (cnt == 65535 || cnt == 65536 || cnt == 65537) begin
                    total++;
                    if (w_ops !== 16'(cnt))
                        $display("FAIL wrap_%0d: ops_issued=%h want %h", cnt, w_ops, 16'(cnt));
                    else pass_cnt++;
                end
                if (cnt == 65537) w_req_valid = '0;
            end
        end
        w_req_valid = '0;
        total++;
        if (cnt != 65537)
            $display("FAIL wrap_timeout: reached %0d handshakes want 65537", cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_back_to_back();
        test_reset_midflight();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
